// File: rtl/uart_baud_fifo.sv
// ---------------------------------------------------------------------------
// uart_baud_fifo
//
// UART-side support block for the uart2wifi core. It contains:
//   - a 16x-oversampling baud tick generator
//   - an 8-bit synchronous byte FIFO with first-word fall-through read data
//   - a small 32-bit register file: three scratch/config words at addresses
//     0..2 and a read-only status word at address 3
//
// Optional feature macro: FIFO_OVERFLOW_FLAG_EN
//   When defined, a sticky overflow flag is kept. It is set by a write attempt
//   while the FIFO is full with no simultaneous read. It is reported in status
//   bit 7. It is cleared by reset or by any register write to address 3.
//   When undefined, there is no overflow logic and status bit 7 reads 0.
//
// Ports:
//   clk         in   1   system clock (50 MHz)
//   rst         in   1   asynchronous, active-high reset
//   enable      in   1   baud generator run enable
//   baud_tick   out  1   one-cycle pulse every BAUD_DIV cycles while enabled
//   fifo_wr     in   1   FIFO write request
//   fifo_rd     in   1   FIFO read request (pop)
//   write_data  in   8   FIFO write data
//   read_data   out  8   FIFO head data (valid when !empty)
//   empty       out  1   FIFO empty
//   full        out  1   FIFO full
//   reg_addr    in   2   register address
//   reg_wdata   in  32   register write data
//   reg_write   in   1   register write strobe
//   reg_read    in   1   register read strobe
//   reg_rdata   out 32   register read data (0 when reg_read=0)
// ---------------------------------------------------------------------------
module uart_baud_fifo #(
    parameter int BAUD_DIV = 163,
    parameter int FIFO_AW  = 4,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              baud_tick,
    input  logic              fifo_wr,
    input  logic              fifo_rd,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              empty,
    output logic              full,
    input  logic [1:0]        reg_addr,
    input  logic [31:0]       reg_wdata,
    input  logic              reg_write,
    input  logic              reg_read,
    output logic [31:0]       reg_rdata
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0]   BAUD_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [FIFO_AW:0]   FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

    // -----------------------------------------------------------------------
    // Baud generator
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] r_baudCnt;

    // The counter freezes while disabled so re-enabling resumes the
    // current baud period instead of restarting it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baudCnt <= '0;
        end else if (enable) begin
            if (r_baudCnt == BAUD_LAST) begin
                r_baudCnt <= '0;
            end else begin
                r_baudCnt <= r_baudCnt + 1'b1;
            end
        end
    end

    assign baud_tick = enable && (r_baudCnt == BAUD_LAST);

    // -----------------------------------------------------------------------
    // Byte FIFO
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wrPtr;
    logic [FIFO_AW-1:0] r_rdPtr;
    logic [FIFO_AW:0]   r_count;
    logic               w_doWrite;
    logic               w_doRead;

    assign empty = (r_count == '0);
    assign full  = (r_count == FULL_COUNT);

    // A write while full is accepted only when a pop frees the slot in
    // the same cycle. When full, wr_ptr equals rd_ptr, so the head byte
    // is presented combinationally before the edge overwrites it.
    assign w_doWrite = fifo_wr && (!full || fifo_rd);
    assign w_doRead  = fifo_rd && !empty;

    always_ff @(posedge clk) begin
        if (w_doWrite) begin
            r_mem[r_wrPtr] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doWrite) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doRead) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doWrite, w_doRead})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign read_data = r_mem[r_rdPtr];

    // -----------------------------------------------------------------------
    // Sticky overflow flag (optional)
    // -----------------------------------------------------------------------
    logic w_overflow;

`ifdef FIFO_OVERFLOW_FLAG_EN
    logic r_overflow;

    // Clear takes priority so a status write always leaves the flag low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (reg_write && (reg_addr == 2'd3)) begin
            r_overflow <= 1'b0;
        end else if (fifo_wr && full && !fifo_rd) begin
            r_overflow <= 1'b1;
        end
    end

    assign w_overflow = r_overflow;
`else
    assign w_overflow = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Register file
    // -----------------------------------------------------------------------
    logic [31:0] r_reg0;
    logic [31:0] r_reg1;
    logic [31:0] r_reg2;
    logic [31:0] w_status;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg0 <= '0;
            r_reg1 <= '0;
            r_reg2 <= '0;
        end else if (reg_write) begin
            case (reg_addr)
                2'd0:    r_reg0 <= reg_wdata;
                2'd1:    r_reg1 <= reg_wdata;
                2'd2:    r_reg2 <= reg_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_status                = '0;
        w_status[0]             = empty;
        w_status[1]             = full;
        w_status[FIFO_AW+2:2]   = r_count;
        w_status[7]             = w_overflow;
    end

    always_comb begin
        reg_rdata = '0;
        if (reg_read) begin
            case (reg_addr)
                2'd0:    reg_rdata = r_reg0;
                2'd1:    reg_rdata = r_reg1;
                2'd2:    reg_rdata = r_reg2;
                default: reg_rdata = w_status;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_baud_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_baud_fifo
//
// Directed self-checking bench for uart_baud_fifo. Inputs are driven just
// after the falling clock edge and outputs are sampled 1 ns later, well away
// from the rising (active) edge.
// ---------------------------------------------------------------------------
module tb_uart_baud_fifo;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        baud_tick;
    logic        fifo_wr;
    logic        fifo_rd;
    logic [7:0]  write_data;
    logic [7:0]  read_data;
    logic        empty;
    logic        full;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_write;
    logic        reg_read;
    logic [31:0] reg_rdata;

    int testsRun;
    int testsFailed;

`ifdef FIFO_OVERFLOW_FLAG_EN
    localparam logic [31:0] OVF_BIT = 32'h0000_0080;
`else
    localparam logic [31:0] OVF_BIT = 32'h0000_0000;
`endif

    uart_baud_fifo #(
        .BAUD_DIV (163),
        .FIFO_AW  (4),
        .DATA_W   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .baud_tick  (baud_tick),
        .fifo_wr    (fifo_wr),
        .fifo_rd    (fifo_rd),
        .write_data (write_data),
        .read_data  (read_data),
        .empty      (empty),
        .full       (full),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_write  (reg_write),
        .reg_read   (reg_read),
        .reg_rdata  (reg_rdata)
    );

    // 50 MHz clock
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h",
                     tag, observed, expected);
        end
    endtask

    // One-cycle register write, driven after the falling edge.
    task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        #1;
        reg_addr  = addr;
        reg_wdata = data;
        reg_write = 1'b1;
        @(negedge clk);
        #1;
        reg_write = 1'b0;
    endtask

    // Combinational register read in the current cycle.
    task automatic readReg(input logic [1:0] addr, output logic [31:0] data);
        reg_addr = addr;
        reg_read = 1'b1;
        #1;
        data     = reg_rdata;
        reg_read = 1'b0;
    endtask

    // Counts falling edges until baud_tick is seen, bounded.
    task automatic waitTick(output int n);
        logic found;
        found = 1'b0;
        n     = 0;
        while (!found && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
            found = baud_tick;
        end
        if (!found) checkOutput("tickTimeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] val;
        logic [31:0] prev;
        int          n;
        int          tickCount;

        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        enable      = 1'b0;
        fifo_wr     = 1'b0;
        fifo_rd     = 1'b0;
        write_data  = '0;
        reg_addr    = '0;
        reg_wdata   = '0;
        reg_write   = 1'b0;
        reg_read    = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        #1;
        checkOutput("resetTick",  32'(baud_tick), 32'd0);
        checkOutput("resetEmpty", 32'(empty),     32'd1);
        checkOutput("resetFull",  32'(full),      32'd0);
        readReg(2'd3, rd);
        checkOutput("resetStatus", rd, 32'h0000_0001);
        readReg(2'd0, rd);
        checkOutput("resetReg0", rd, 32'h0);
        rst = 1'b0;

        // ---- registers: write then read next cycle, twice per address ----
        prev = '0;
        for (int rep = 0; rep < 2; rep++) begin
            for (int a = 0; a < 3; a++) begin
                val = $urandom;
                applyStimulus(2'(a), val);
                readReg(2'(a), rd);
                checkOutput($sformatf("regRdBack%0d_%0d", a, rep), rd, val);
                if (a == 0) prev = val;
            end
        end
        reg_addr = 2'd0;
        #1;
        checkOutput("regNoReadStrobe", reg_rdata, 32'h0);

        // write and read together: old value now, new value after the edge
        @(negedge clk);
        #1;
        reg_addr  = 2'd0;
        reg_wdata = 32'hA5A5_5A5A;
        reg_write = 1'b1;
        reg_read  = 1'b1;
        #1;
        checkOutput("regRdWrSameCycle", reg_rdata, prev);
        @(negedge clk);
        #1;
        reg_write = 1'b0;
        #1;
        checkOutput("regRdWrAfter", reg_rdata, 32'hA5A5_5A5A);
        reg_read = 1'b0;

        // write to status address must not disturb the status word
        applyStimulus(2'd3, 32'hFFFF_FFFF);
        readReg(2'd3, rd);
        checkOutput("statusWriteIgnored", rd, 32'h0000_0001);

        // ---- baud generator ----
        @(negedge clk);
        enable = 1'b1;
        waitTick(n);
        checkOutput("baudFirstLatency", 32'(n), 32'd162);
        waitTick(n);
        checkOutput("baudPeriod", 32'(n), 32'd163);
        @(negedge clk);
        #1;
        checkOutput("baudTickOneCycle", 32'(baud_tick), 32'd0);
        // counter now 0 here; run to 49 then freeze for 10 cycles
        repeat (49) @(negedge clk);
        enable    = 1'b0;
        tickCount = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (baud_tick) tickCount++;
        end
        checkOutput("baudNoTickDisabled", 32'(tickCount), 32'd0);
        enable = 1'b1;
        // resumes from 49: 162-49 = 113 more cycles to the next tick
        waitTick(n);
        checkOutput("baudResume", 32'(n), 32'd113);

        // ---- FIFO fill: 21 writes, 5 dropped ----
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            #1;
            if (i == 15) checkOutput("fillNotFull15", 32'(full), 32'd0);
            if (i == 16) checkOutput("fillFull16",    32'(full), 32'd1);
            fifo_wr    = 1'b1;
            write_data = 8'(4 + i);
        end
        @(negedge clk);
        #1;
        fifo_wr = 1'b0;
        readReg(2'd3, rd);
        checkOutput("fillStatus", rd, 32'h0000_0042 | OVF_BIT);

        // status write clears the overflow flag (no effect without it)
        applyStimulus(2'd3, 32'h0000_0000);
        readReg(2'd3, rd);
        checkOutput("statusAfterClear", rd, 32'h0000_0042);

        // ---- FIFO drain 8 ----
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("drain%0d", i), 32'(read_data), 32'(8'(4 + i)));
            fifo_rd = 1'b1;
        end
        // ---- simultaneous rd+wr for 8 cycles ----
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("rdwr%0d", i), 32'(read_data), 32'(8'(8'h0C + i)));
            fifo_rd    = 1'b1;
            fifo_wr    = 1'b1;
            write_data = 8'(8'h40 + i);
        end
        @(negedge clk);
        #1;
        fifo_wr = 1'b0;
        fifo_rd = 1'b0;
        readReg(2'd3, rd);
        checkOutput("rdwrStatusCount8", rd, 32'h0000_0020);

        // ---- drain remaining 8, order preserved ----
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("tail%0d", i), 32'(read_data), 32'(8'(8'h40 + i)));
            fifo_rd = 1'b1;
        end
        @(negedge clk);
        #1;
        checkOutput("emptyAfterDrain", 32'(empty), 32'd1);

        // ---- read while empty is ignored ----
        repeat (3) @(negedge clk);
        #1;
        fifo_rd = 1'b0;
        checkOutput("emptyStillEmpty", 32'(empty), 32'd1);
        readReg(2'd3, rd);
        checkOutput("emptyStatus", rd, 32'h0000_0001);

        // ---- rd+wr while empty: write only ----
        @(negedge clk);
        #1;
        fifo_rd    = 1'b1;
        fifo_wr    = 1'b1;
        write_data = 8'h77;
        @(negedge clk);
        #1;
        fifo_rd = 1'b0;
        fifo_wr = 1'b0;
        readReg(2'd3, rd);
        checkOutput("emptyRdWrStatus", rd, 32'h0000_0004);
        checkOutput("emptyRdWrData", 32'(read_data), 32'h77);
        checkOutput("emptyRdWrNotEmpty", 32'(empty), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
